// File: rtl/div_pkg.sv
// div_pkg
//   Shared constants and types for the 16-by-8 sequential divider.
//   - DIVIDEND_W / DIVISOR_W / CNT_W : datapath and iteration-counter widths
//   - Q_DZ                           : quotient reported for a zero divisor
//   - state_t                        : controller states S_IDLE, S_RUN, S_DONE
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 4;

  localparam logic [DIVIDEND_W-1:0] Q_DZ = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_9_bit.sv
// sub_9_bit
//   Combinational 9-bit unsigned subtractor used for the restoring trial.
//   Ports:
//     a      in  9  minuend (shifted partial remainder)
//     b      in  9  subtrahend (zero-extended divisor)
//     diff   out 9  a - b, modulo 2^9
//     borrow out 1  1 when a < b (trial failed, keep a)
module sub_9_bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);

  logic [9:0] wide;

  // One extra bit on the left catches the borrow out of bit 8.
  assign wide   = {1'b0, a} - {1'b0, b};
  assign diff   = wide[8:0];
  assign borrow = wide[9];

endmodule

// File: rtl/div_16_by_8.sv
// div_16_by_8
//   Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned
//   divisor, one quotient bit per clock, 16 iterations per division.
//   Ports:
//     clk         in  1   rising-edge clock
//     rst         in  1   asynchronous, active-high reset
//     start       in  1   request, sampled only while busy=0
//     dividend    in  16  captured on an accepted start
//     divisor     in  8   captured on an accepted start
//     busy        out 1   division in progress
//     done        out 1   one-cycle pulse, results valid from this cycle
//     quotient    out 16  held until the next done
//     remainder   out 8   held until the next done
//     div_by_zero out 1   qualifies the held results
//
//   Handshake: a request is accepted on any rising edge where start=1 and
//   busy=0 (idle or in the done cycle). Once accepted, busy stays high for the
//   16 iteration cycles and start is ignored; operands were captured at
//   acceptance, so later input changes are invisible. done pulses for one
//   cycle when results land; a zero divisor skips the iterations and reports
//   done in the very next cycle. Holding start high through done chains
//   divisions back to back.
module div_16_by_8
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  state_t                  state, state_n;
  logic [DIVIDEND_W-1:0]   sr, sr_n;          // dividend shifting out, quotient shifting in
  logic [DIVISOR_W:0]      part, part_n;      // 9-bit partial remainder
  logic [DIVISOR_W-1:0]    dvs, dvs_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [DIVIDEND_W-1:0]   quotient_n;
  logic [DIVISOR_W-1:0]    remainder_n;
  logic                    dz_n;

  logic [DIVISOR_W:0]      shifted;
  logic [DIVISOR_W:0]      trial;
  logic                    borrow;

  // The partial remainder always ends an iteration below the divisor, so its
  // MSB is zero going into the next shift and is not needed there.
  logic                    unused_part_msb;
  assign unused_part_msb = part[DIVISOR_W];

  // Left shift of {partial, dividend_sr}: the dividend MSB enters the partial.
  assign shifted = {part[DIVISOR_W-1:0], sr[DIVIDEND_W-1]};

  sub_9_bit u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Status outputs decode directly from the state register.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sr          <= '0;
      part        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      part        <= part_n;
      dvs         <= dvs_n;
      cnt         <= cnt_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= dz_n;
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    part_n      = part;
    dvs_n       = dvs;
    cnt_n       = cnt;
    quotient_n  = quotient;
    remainder_n = remainder;
    dz_n        = div_by_zero;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor != '0) begin
            sr_n    = dividend;
            dvs_n   = divisor;
            part_n  = '0;
            cnt_n   = '1;
            state_n = S_RUN;
          end else begin
            quotient_n  = Q_DZ;
            remainder_n = '0;
            dz_n        = 1'b1;
            state_n     = S_DONE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end

      S_RUN: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        part_n = borrow ? shifted : trial;
        sr_n   = {sr[DIVIDEND_W-2:0], ~borrow};
        cnt_n  = cnt - 1'b1;
        if (cnt == '0) begin
          quotient_n  = sr_n;
          remainder_n = part_n[DIVISOR_W-1:0];
          dz_n        = 1'b0;
          state_n     = S_DONE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_16_by_8.sv
// tb_div_16_by_8
//   Self-checking bench for div_16_by_8. A cycle-level behavioural model built
//   from plain division arithmetic predicts every output each cycle; a single
//   compare process checks the DUT against it on the falling edge. Directed
//   cases pin the model with hand-computed literals; a random run follows.
module tb_div_16_by_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  div_16_by_8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The team's 8x8 multiplier, used to rebuild dividend from the results.
  function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] b);
    return {8'h00, a} * {8'h00, b};
  endfunction

  // ---------------- behavioural model ----------------
  // m_cnt: cycles of work left; the model is busy while it is non-zero.
  // exp_q: pending result {dz, quotient, remainder} of the division in flight.
  int          m_cnt;
  bit          m_done;
  logic [15:0] m_q;
  logic [7:0]  m_r;
  bit          m_dz;
  logic [15:0] op_dvd;
  logic [7:0]  op_dvs;
  logic [24:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
      exp_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_done && exp_q.size() > 0) begin
        logic [24:0] res;
        res  = exp_q.pop_front();
        m_dz = res[24];
        m_q  = res[23:8];
        m_r  = res[7:0];
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        op_dvd = dividend;
        op_dvs = divisor;
        if (divisor == 8'd0) begin
          m_done = 1'b1;
          m_q    = 16'hFFFF;
          m_r    = 8'h00;
          m_dz   = 1'b1;
        end else begin
          m_cnt = 16;
          exp_q.push_back({1'b0, dividend / {8'h00, divisor}, 8'(dividend % {8'h00, divisor})});
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, (m_cnt > 0));
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_dz);
      if (done && !div_by_zero && op_dvs != 8'd0) begin
        logic [23:0] recon;
        recon = ({8'h00, mul8x8(quotient[15:8], op_dvs)} << 8)
              + {8'h00, mul8x8(quotient[7:0], op_dvs)}
              + {16'h0000, remainder};
        check("identity", recon, {8'h00, op_dvd});
        check("rem_lt_div", (remainder < op_dvs), 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the accepting edge (E0).
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // edges = number of clock edges after E0 before done is seen (-1 on timeout).
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz,
                        input int elat);
    int e;
    start_op(dvd, dvs);
    wait_done(e);
    check({tag, "_latency"}, e, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, edz);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e;
    int gap;
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // reset state
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_q", quotient, 16'h0000);
    check("reset_r", remainder, 8'h00);
    check("reset_dz", div_by_zero, 1'b0);

    // 1000 / 7
    run_op("d1000_7", 16'h03E8, 8'h07, 16'd142, 8'd6, 1'b0, 16);

    // back-to-back: FFFF/1 then 00C8/FA with start held through DONE
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'hFFFF; divisor = 8'h01;
    @(posedge clk); #1;
    dividend = 16'h00C8; divisor = 8'hFA;
    wait_done(e);
    check("b2b1_latency", e, 16);
    check("b2b1_q", quotient, 16'hFFFF);
    check("b2b1_r", remainder, 8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    gap = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        gap = i;
        break;
      end
    end
    check("b2b_gap", gap, 17);
    check("b2b2_q", quotient, 16'h0000);
    check("b2b2_r", remainder, 8'd200);
    check("b2b2_dz", div_by_zero, 1'b0);

    // divide by zero, then a normal division clears the flag
    run_op("dz", 16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 0);
    run_op("d1234_10", 16'h1234, 8'h10, 16'h0123, 8'h04, 1'b0, 16);

    // start while busy is ignored
    start_op(16'd50000, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd9; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'hAAAA; divisor = 8'h55;
    wait_done(e);
    check("ignore_q", quotient, 16'd16666);
    check("ignore_r", remainder, 8'd2);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n++;
    end
    check("ignore_extra_done", n, 0);

    // asynchronous reset in the middle of a run
    start_op(16'd40000, 8'd7);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_q", quotient, 16'h0000);
    check("arst_r", remainder, 8'h00);
    check("arst_dz", div_by_zero, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    check("arst_no_done", n, 0);
    run_op("d100_9", 16'd100, 8'd9, 16'd11, 8'd1, 1'b0, 16);

    // random regression
    for (int k = 0; k < 2500; k++) begin
      logic [15:0] dvd;
      logic [7:0]  dvs;
      int          sel;
      sel = $urandom_range(0, 9);
      dvd = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 19) == 0) dvd = 16'hFFFF;
      case (sel)
        0:       dvs = 8'd0;
        1:       dvs = 8'd1;
        2:       dvs = 8'd255;
        default: dvs = 8'($urandom_range(0, 255));
      endcase
      start_op(dvd, dvs);
      wait_done(e);
      if (dvs == 8'd0) begin
        check("rnd_latency", e, 0);
        check("rnd_q", quotient, 16'hFFFF);
        check("rnd_dz", div_by_zero, 1'b1);
      end else begin
        check("rnd_latency", e, 16);
        check("rnd_q", quotient, dvd / {8'h00, dvs});
        check("rnd_r", remainder, 8'(dvd % {8'h00, dvs}));
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
